// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - shares one registered-output ROM among NUM_REQ requesters
`timescale 1ns/1ps
module rom_read_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int AW          = 6,
  parameter int DW          = 4,
  parameter int ROM_LATENCY = 1,
  parameter int PRIO0       = 1,
  parameter int MAX_WAIT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DW-1:0]         rom_data_i,
  output logic                  busy_o
);

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int DEPTH = ROM_LATENCY + 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WW-1:0] wait_q [NUM_REQ];
  logic [WW-1:0] wait_d [NUM_REQ];
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] rdata_q;
  logic [DEPTH-1:0] tag_vld_q;
  logic [IW-1:0]    tag_idx_q [DEPTH];

  logic          win_valid;
  logic          win_rr;
  logic [IW-1:0] win_idx;
  logic          ret_valid;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Starved requesters first, then the privileged requester 0, then round-robin.
  always_comb begin
    win_valid = 1'b0;
    win_rr    = 1'b0;
    win_idx   = '0;
    if (MAX_WAIT > 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_valid && req_i[i] && wait_q[i] == WW'(MAX_WAIT)) begin
          win_valid = 1'b1;
          win_rr    = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end
    if (!win_valid && PRIO0 != 0 && req_i[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_valid && req_i[rr_idx(rr_ptr_q, k)]) begin
        win_valid = 1'b1;
        win_rr    = 1'b1;
        win_idx   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (win_valid && !rst_i) gnt_o[win_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    if (win_valid) begin
      rom_addr_d = addr_i[win_idx*AW +: AW];
      if (win_rr) rr_ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_i[i] || gnt_o[i])            wait_d[i] = '0;
      else if (wait_q[i] != WW'(MAX_WAIT))  wait_d[i] = wait_q[i] + 1'b1;
      else                                  wait_d[i] = wait_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      tag_vld_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      for (int s = 0; s < DEPTH; s++) tag_idx_q[s] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rom_addr_q   <= rom_addr_d;
      rdata_q      <= rdata_o;
      tag_vld_q[0] <= win_valid;
      tag_idx_q[0] <= win_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  // Data passes straight from the ROM on the return cycle and is held afterwards.
  assign ret_valid  = tag_vld_q[DEPTH-1] && !rst_i;
  assign rdata_o    = ret_valid ? rom_data_i : rdata_q;
  assign rom_addr_o = rom_addr_q;
  assign busy_o     = |tag_vld_q;

  always_comb begin
    rvalid_o = '0;
    if (ret_valid) rvalid_o[tag_idx_q[DEPTH-1]] = 1'b1;
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - directed self-checking bench for rom_read_arbiter
`timescale 1ns/1ps
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [17:0] addr;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [3:0]  rdata;
  logic [5:0]  rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_read_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .addr_i     (addr),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .busy_o     (busy)
  );

  // ROM contents: (7*a + 3) mod 16
  function automatic logic [3:0] rom_f(input logic [5:0] a);
    logic [9:0] t;
    t = 10'(a) * 10'd7 + 10'd3;
    return t[3:0];
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  // Expected grant pattern with all three requesting and PRIO0=1, MAX_WAIT=15
  function automatic logic [2:0] exp_g4(input int c);
    if (c < 15)  return 3'b001;
    if (c == 15) return 3'b010;
    if (c == 16) return 3'b100;
    if (c == 17) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [3:0] exp_d4(input logic [2:0] g);
    case (g)
      3'b001:  return 4'd3;
      3'b010:  return 4'd6;
      default: return 4'd12;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    tick();
    tick();
    req = 3'b111;
    #3;
    check_eq("rst_gnt_masked", 32'(gnt), 0);
    check_eq("rst_rvalid", 32'(rvalid), 0);
    check_eq("rst_rdata", 32'(rdata), 0);
    check_eq("rst_rom_addr", 32'(rom_addr), 0);
    check_eq("rst_busy", 32'(busy), 0);
    req = '0;

    // single read from requester 1
    tick();
    rst  = 1'b0;
    req  = 3'b010;
    addr = {6'd0, 6'd5, 6'd0};
    #3;
    check_eq("t1_gnt", 32'(gnt), 32'b010);
    tick();
    req = '0;
    #3;
    check_eq("t1_gnt_idle", 32'(gnt), 0);
    check_eq("t1_busy1", 32'(busy), 1);
    check_eq("t1_rvalid_early", 32'(rvalid), 0);
    check_eq("t1_rom_addr", 32'(rom_addr), 5);
    tick();
    #3;
    check_eq("t1_rvalid", 32'(rvalid), 32'b010);
    check_eq("t1_rdata", 32'(rdata), 6);
    check_eq("t1_busy2", 32'(busy), 1);
    tick();
    #3;
    check_eq("t1_busy_low", 32'(busy), 0);
    check_eq("t1_rvalid_off", 32'(rvalid), 0);
    check_eq("t1_rdata_hold", 32'(rdata), 6);

    // round-robin between 1 and 2
    do_reset();
    addr = {6'd20, 6'd10, 6'd0};
    req  = 3'b110;
    for (int c = 0; c < 8; c++) begin
      #3;
      check_eq("t2_gnt", 32'(gnt), (c % 2 == 0) ? 32'b010 : 32'b100);
      if (c >= 2) begin
        check_eq("t2_rvalid", 32'(rvalid), (c % 2 == 0) ? 32'b010 : 32'b100);
        check_eq("t2_rdata", 32'(rdata), (c % 2 == 0) ? 32'd9 : 32'd15);
      end
      tick();
    end
    req = '0;

    // starvation rescue of requester 2 against privileged requester 0
    do_reset();
    addr = {6'd2, 6'd0, 6'd1};
    req  = 3'b101;
    for (int c = 0; c < 17; c++) begin
      #3;
      check_eq("t3_gnt", 32'(gnt), (c == 15) ? 32'b100 : 32'b001);
      tick();
      if (c == 15) req = 3'b001;
    end
    req = '0;
    #3;
    check_eq("t3_rvalid2", 32'(rvalid), 32'b100);
    check_eq("t3_rdata2", 32'(rdata), 1);

    // all three requesting
    do_reset();
    addr = {6'd63, 6'd21, 6'd0};
    req  = 3'b111;
    for (int c = 0; c < 20; c++) begin
      if (c == 18) req = '0;
      #3;
      check_eq("t4_gnt", 32'(gnt), 32'(exp_g4(c)));
      check_eq("t4_onehot", 32'($countones(gnt) <= 1), 1);
      if (c >= 2) begin
        check_eq("t4_rvalid", 32'(rvalid), 32'(exp_g4(c - 2)));
        check_eq("t4_rdata", 32'(rdata), 32'(exp_d4(exp_g4(c - 2))));
      end
      tick();
    end

    // reset with two reads in flight
    do_reset();
    addr = {6'd20, 6'd5, 6'd7};
    req  = 3'b010;
    #3;
    check_eq("t5_gnt_a", 32'(gnt), 32'b010);
    tick();
    req = 3'b100;
    #3;
    check_eq("t5_gnt_b", 32'(gnt), 32'b100);
    tick();
    rst = 1'b1;
    req = '0;
    #3;
    check_eq("t5_rvalid_in_rst", 32'(rvalid), 0);
    check_eq("t5_gnt_in_rst", 32'(gnt), 0);
    tick();
    rst = 1'b0;
    req = 3'b001;
    #3;
    check_eq("t5_rvalid_after", 32'(rvalid), 0);
    check_eq("t5_busy_after", 32'(busy), 0);
    check_eq("t5_rom_addr_after", 32'(rom_addr), 0);
    check_eq("t5_rdata_after", 32'(rdata), 0);
    check_eq("t5_gnt_new", 32'(gnt), 32'b001);
    tick();
    req = '0;
    #3;
    check_eq("t5_rvalid_e", 32'(rvalid), 0);
    check_eq("t5_busy_e", 32'(busy), 1);
    tick();
    #3;
    check_eq("t5_rvalid_new", 32'(rvalid), 32'b001);
    check_eq("t5_rdata_new", 32'(rdata), 4);
    tick();

    // idle after traffic
    for (int c = 0; c < 10; c++) begin
      #3;
      check_eq("t6_busy", 32'(busy), 0);
      check_eq("t6_rvalid", 32'(rvalid), 0);
      check_eq("t6_rom_addr", 32'(rom_addr), 7);
      tick();
    end
    check_eq("t6_rdata_hold", 32'(rdata), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
